// File: rtl/p_adder_unit_pkg.sv
// Shared constants for the 5-bit programmable adder/subtractor.
// The op-select codes set how operand B is conditioned before the add.
package p_adder_unit_pkg;

    localparam int WIDTH = 5;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_PASS = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

endpackage

// File: rtl/p_adder_unit_bit.sv
// One bit slice: B conditioning mux followed by a full adder.
module p_adder_bit
    import p_adder_unit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic s1,
    input  logic s0,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic bx;

    always_comb begin
        bx = b;
        case ({s1, s0})
            OP_ADD:  bx = b;
            OP_PASS: bx = 1'b0;
            OP_SUB:  bx = ~b;
            OP_DEC:  bx = 1'b1;
            default: bx = b;
        endcase
    end

    assign sum = a ^ bx ^ ci;
    assign co  = (a & bx) | (a & ci) | (bx & ci);

endmodule

// File: rtl/p_adder_unit.sv
// 5-bit ripple-carry adder/subtractor with registered result and carry-out.
// The timer ties b=1, cin=1, select=10 so this computes n-1.
module p_adder_unit
    import p_adder_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a4,
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b4,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    input  logic cin,
    input  logic s1,
    input  logic s0,
    output logic o4,
    output logic o3,
    output logic o2,
    output logic o1,
    output logic o0,
    output logic carry
);

    logic [WIDTH-1:0] a_vec;
    logic [WIDTH-1:0] b_vec;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] o_reg;
    logic             carry_reg;

    assign a_vec = {a4, a3, a2, a1, a0};
    assign b_vec = {b4, b3, b2, b1, b0};
    assign c[0]  = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        p_adder_bit u_bit (
            .a   (a_vec[i]),
            .b   (b_vec[i]),
            .s1  (s1),
            .s0  (s0),
            .ci  (c[i]),
            .sum (sum[i]),
            .co  (c[i+1])
        );
    end

    // Reset wins over the computation, discarding any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_reg     <= '0;
            carry_reg <= 1'b0;
        end else begin
            o_reg     <= sum;
            carry_reg <= c[WIDTH];
        end
    end

    assign {o4, o3, o2, o1, o0} = o_reg;
    assign carry = carry_reg;

endmodule

// File: tb/tb_p_adder_unit.sv
// Self-checking bench: directed steps plus random traffic against an arithmetic model.
module tb_p_adder_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] a = '0;
    logic [4:0] b = '0;
    logic       cin = 1'b0;
    logic [1:0] s = '0;
    logic [4:0] o;
    logic       carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_adder_unit dut (
        .clk   (clk),
        .reset (reset),
        .a4 (a[4]), .a3 (a[3]), .a2 (a[2]), .a1 (a[1]), .a0 (a[0]),
        .b4 (b[4]), .b3 (b[3]), .b2 (b[2]), .b1 (b[1]), .b0 (b[0]),
        .cin   (cin),
        .s1    (s[1]),
        .s0    (s[0]),
        .o4 (o[4]), .o3 (o[3]), .o2 (o[2]), .o1 (o[1]), .o0 (o[0]),
        .carry (carry)
    );

    // Reference: unsigned A + conditioned B + cin, low 5 bits result, bit 5 carry.
    function automatic logic [5:0] model(input logic [4:0] ma, input logic [4:0] mb,
                                         input logic mc, input logic [1:0] ms);
        int bx;
        int total;
        case (ms)
            2'd0:    bx = int'(mb);
            2'd1:    bx = 0;
            2'd2:    bx = 31 - int'(mb);
            default: bx = 31;
        endcase
        total = int'(ma) + bx + int'(mc);
        return 6'(total);
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] expected);
        checks++;
        assert ({carry, o} === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: got o=%b carry=%b, want o=%b carry=%b",
                   tag, o, carry, expected[4:0], expected[5]);
        end
    endtask

    // Drive one operation, clock it in and check the registered result just after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic [4:0] na,
                                 input logic [4:0] nb, input logic nc, input logic [1:0] ns);
        logic [5:0] expected;
        reset = rst;
        a = na;
        b = nb;
        cin = nc;
        s = ns;
        expected = rst ? 6'd0 : model(na, nb, nc, ns);
        @(posedge clk);
        #1;
        checkOutput(tag, expected);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(negedge clk);
        applyStimulus("reset0", 1'b1, 5'b10101, 5'b01110, 1'b1, 2'b00);
        applyStimulus("reset1", 1'b1, 5'b11111, 5'b11111, 1'b1, 2'b11);
        checks++;
        assert ({carry, o} === 6'b0_00000)
        else begin
            errors++;
            $error("[TB] FAIL reset_hold: got o=%b carry=%b, want 00000/0", o, carry);
        end
        applyStimulus("first_result", 1'b0, 5'b00011, 5'b00001, 1'b1, 2'b10);
        checks++;
        assert ({carry, o} === 6'b1_00010)
        else begin
            errors++;
            $error("[TB] FAIL first_const: got o=%b carry=%b, want 00010/1", o, carry);
        end

        applyStimulus("timer_dec22", 1'b0, 5'b10110, 5'b00001, 1'b1, 2'b10);
        checks++;
        assert ({carry, o} === 6'b1_10101)
        else begin
            errors++;
            $error("[TB] FAIL timer_const: got o=%b carry=%b, want 10101/1", o, carry);
        end
        for (int n = 31; n >= 1; n--) begin
            applyStimulus("timer_sweep", 1'b0, 5'(n), 5'b00001, 1'b1, 2'b10);
        end

        applyStimulus("borrow_zero", 1'b0, 5'b00000, 5'b00001, 1'b1, 2'b10);
        checks++;
        assert ({carry, o} === 6'b0_11111)
        else begin
            errors++;
            $error("[TB] FAIL borrow_const: got o=%b carry=%b, want 11111/0", o, carry);
        end
        applyStimulus("borrow_5m8", 1'b0, 5'b00101, 5'b01000, 1'b1, 2'b10);
        applyStimulus("add_ovf", 1'b0, 5'b11111, 5'b00001, 1'b0, 2'b00);
        checks++;
        assert ({carry, o} === 6'b1_00000)
        else begin
            errors++;
            $error("[TB] FAIL add_ovf_const: got o=%b carry=%b, want 00000/1", o, carry);
        end
        applyStimulus("add_cin", 1'b0, 5'b01010, 5'b00101, 1'b1, 2'b00);
        applyStimulus("pass_inc", 1'b0, 5'b00101, 5'b10011, 1'b1, 2'b01);
        applyStimulus("dec_zero", 1'b0, 5'b00000, 5'b01100, 1'b0, 2'b11);
        checks++;
        assert ({carry, o} === 6'b0_11111)
        else begin
            errors++;
            $error("[TB] FAIL dec_zero_const: got o=%b carry=%b, want 11111/0", o, carry);
        end
        applyStimulus("dec_five", 1'b0, 5'b00101, 5'b00000, 1'b0, 2'b11);
        applyStimulus("dec_xfer", 1'b0, 5'b01001, 5'b00000, 1'b1, 2'b11);

        for (int m = 0; m < 8; m++) begin
            applyStimulus("b2b_modes", 1'b0, 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'(m % 4));
        end
        applyStimulus("mid_reset", 1'b1, 5'b11011, 5'b00111, 1'b1, 2'b00);
        applyStimulus("resume", 1'b0, 5'b11011, 5'b00111, 1'b1, 2'b00);

        for (int k = 0; k < 300; k++) begin
            applyStimulus("random", ($urandom_range(0, 19) == 0),
                          5'($urandom), 5'($urandom), 1'($urandom), 2'($urandom));
        end

        // Outputs must hold between edges: sample again mid-cycle without a new edge.
        @(negedge clk);
        checks++;
        assert ({carry, o} === (reset ? 6'd0 : model(a, b, cin, s)))
        else begin
            errors++;
            $error("[TB] FAIL hold: got o=%b carry=%b", o, carry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
